// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an in-order pipeline: memory wait/drain FSM, load-use bubbles,
// deferred branch redirect and exception flush. Optional perf counters: PIPE_HAZARD_CTRL_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES   = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int HAZARD_STAGE = 2,
  parameter int MEM_STAGE    = 3,
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch,
  input  logic                  exception,
  input  logic                  hazard,
  input  logic                  imem_busy,
  input  logic                  dmem_busy,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  redir_pending,
  output logic [1:0]            ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_events
`endif
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_MEM_DRAIN = 2'd2,
    ST_EXC       = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              drain_q, drain_d;
  logic                    redir_q, redir_d;
  logic                    exc_act, mem_act, haz_act, imem_act;
  logic [NUM_STAGES-1:0]   stall_raw, flush_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      drain_q <= 4'd0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      redir_q <= redir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (exception) begin
      state_d = ST_EXC;
    end else begin
      case (state_q)
        ST_RUN:      if (dmem_busy) state_d = ST_MEM_WAIT;
        ST_MEM_WAIT: begin
          if (!dmem_busy) begin
            if (DRAIN_CYCLES > 0) begin
              state_d = ST_MEM_DRAIN;
              drain_d = DRAIN_LOAD;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_MEM_DRAIN: begin
          if (drain_q == 4'd0) state_d = ST_RUN;
          else                 drain_d = drain_q - 4'd1;
        end
        ST_EXC:      state_d = dmem_busy ? ST_MEM_WAIT : ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  // Request priority: exception > memory > load-use hazard > fetch busy.
  always_comb begin
    exc_act  = exception || (state_q == ST_EXC);
    mem_act  = !exc_act && ((state_q != ST_RUN) || dmem_busy);
    haz_act  = !exc_act && !mem_act && hazard;
    imem_act = !exc_act && !mem_act && !hazard && imem_busy;

    stall_raw = '0;
    flush_raw = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (exc_act && i <= MEM_STAGE)      flush_raw[i] = 1'b1;
      if (mem_act && i <= MEM_STAGE)      stall_raw[i] = 1'b1;
      if (mem_act && i == MEM_STAGE + 1)  flush_raw[i] = 1'b1;
      if (haz_act && i < HAZARD_STAGE)    stall_raw[i] = 1'b1;
      if (haz_act && i == HAZARD_STAGE)   flush_raw[i] = 1'b1;
      if (imem_act && i == 0)             stall_raw[i] = 1'b1;
      if (imem_act && i == 1)             flush_raw[i] = 1'b1;
    end

    // A stalled branch register keeps its flush back; branch is re-presented later.
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (branch && i < BRANCH_STAGE)                      flush_raw[i] = 1'b1;
      if (branch && i == BRANCH_STAGE && !stall_raw[i])    flush_raw[i] = 1'b1;
    end
    if ((branch && !imem_act) || (redir_q && !imem_busy)) flush_raw[0] = 1'b1;

    if (exc_act)                  redir_d = 1'b0;
    else if (branch && imem_act)  redir_d = 1'b1;
    else if (!imem_busy)          redir_d = 1'b0;
    else                          redir_d = redir_q;

    if (reset) begin
      stall = '0;
      flush = '1;
    end else begin
      flush = flush_raw;
      stall = stall_raw & ~flush_raw;
    end
    redir_pending = redir_q;
    ctrl_state    = state_q;
  end

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall[0] && (stall_cycles != '1))                stall_cycles <= stall_cycles + 1'b1;
      if ((branch || exception) && (flush_events != '1))   flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl (default parameters, NUM_STAGES=5).
module tb_pipe_hazard_ctrl;
  localparam int NS = 5;
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif
  localparam int OBS_W = 2 * NS + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic branch = 1'b0, exception = 1'b0, hazard = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0;
  logic [NS-1:0] stall, flush;
  logic          redir_pending;
  logic [1:0]    ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  int checks = 0;
  int failures = 0;

  // Inputs packed as {branch, exception, hazard, imem_busy, dmem_busy}.
  typedef struct {
    logic [4:0]    in;
    logic [NS-1:0] exp_stall;
    logic [NS-1:0] exp_flush;
    logic          exp_redir;
    logic [1:0]    exp_state;
  } vec_t;

  vec_t             vecs[$];
  logic [OBS_W-1:0] exp_q[$];

  pipe_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .branch(branch), .exception(exception), .hazard(hazard),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .stall(stall), .flush(flush),
    .redir_pending(redir_pending), .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] in, input logic [NS-1:0] st, input logic [NS-1:0] fl,
                              input logic rd, input logic [1:0] s);
    vec_t v;
    v.in = in; v.exp_stall = st; v.exp_flush = fl; v.exp_redir = rd; v.exp_state = s;
    return v;
  endfunction

  task automatic drive(input logic [4:0] in);
    {branch, exception, hazard, imem_busy, dmem_busy} = in;
  endtask

  task automatic check(input string name, input logic [OBS_W-1:0] exp);
    logic [OBS_W-1:0] got;
    got = {stall, flush, redir_pending, ctrl_state};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got stall=%b flush=%b redir=%b state=%0d, expected stall=%b flush=%b redir=%b state=%0d",
               name, got[OBS_W-1 -: NS], got[OBS_W-NS-1 -: NS], got[2], got[1:0],
               exp[OBS_W-1 -: NS], exp[OBS_W-NS-1 -: NS], exp[2], exp[1:0]);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    //            b e h i d    stall     flush     rd st
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0)); // idle
    vecs.push_back(mk(5'b00100, 5'b00011, 5'b00100, 0, 0)); // hazard alone
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0));
    vecs.push_back(mk(5'b00001, 5'b01111, 5'b10000, 0, 0)); // dmem busy x3, then drain
    vecs.push_back(mk(5'b00001, 5'b01111, 5'b10000, 0, 1));
    vecs.push_back(mk(5'b00001, 5'b01111, 5'b10000, 0, 1));
    vecs.push_back(mk(5'b00000, 5'b01111, 5'b10000, 0, 1));
    vecs.push_back(mk(5'b00000, 5'b01111, 5'b10000, 0, 2));
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0));
    vecs.push_back(mk(5'b00101, 5'b01111, 5'b10000, 0, 0)); // hazard masked by memory stall
    vecs.push_back(mk(5'b00100, 5'b01111, 5'b10000, 0, 1));
    vecs.push_back(mk(5'b00100, 5'b01111, 5'b10000, 0, 2));
    vecs.push_back(mk(5'b00100, 5'b00011, 5'b00100, 0, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0));
    vecs.push_back(mk(5'b10010, 5'b00001, 5'b00110, 0, 0)); // branch while fetch busy
    vecs.push_back(mk(5'b00010, 5'b00001, 5'b00010, 1, 0));
    vecs.push_back(mk(5'b00010, 5'b00001, 5'b00010, 1, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00001, 1, 0)); // deferred redirect
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0));
    vecs.push_back(mk(5'b10000, 5'b00000, 5'b00111, 0, 0)); // branch alone
    vecs.push_back(mk(5'b10100, 5'b00000, 5'b00111, 0, 0)); // branch over hazard bubble
    vecs.push_back(mk(5'b10001, 5'b01100, 5'b10011, 0, 0)); // branch during memory stall
    vecs.push_back(mk(5'b00000, 5'b01111, 5'b10000, 0, 1));
    vecs.push_back(mk(5'b00000, 5'b01111, 5'b10000, 0, 2));
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0));
    vecs.push_back(mk(5'b00001, 5'b01111, 5'b10000, 0, 0)); // exception during dmem busy
    vecs.push_back(mk(5'b01001, 5'b00000, 5'b01111, 0, 1));
    vecs.push_back(mk(5'b00001, 5'b00000, 5'b01111, 0, 3));
    vecs.push_back(mk(5'b00001, 5'b01111, 5'b10000, 0, 1));
    vecs.push_back(mk(5'b00000, 5'b01111, 5'b10000, 0, 1));
    vecs.push_back(mk(5'b00000, 5'b01111, 5'b10000, 0, 2));
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0));
    vecs.push_back(mk(5'b10010, 5'b00001, 5'b00110, 0, 0)); // exception cancels pending redirect
    vecs.push_back(mk(5'b01010, 5'b00000, 5'b01111, 1, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 5'b01111, 0, 3));
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0));
    vecs.push_back(mk(5'b00010, 5'b00001, 5'b00010, 0, 0)); // fetch busy alone
    vecs.push_back(mk(5'b00110, 5'b00011, 5'b00100, 0, 0)); // hazard outranks fetch busy
    vecs.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 0));

    // Clock/reset: reset held from time 0.
    drive(5'b00000);
    #2;
    check("reset_state", {5'b00000, 5'b11111, 1'b0, 2'd0});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].in);
      exp_q.push_back({vecs[k].exp_stall, vecs[k].exp_flush, vecs[k].exp_redir, vecs[k].exp_state});
      #2;
      check($sformatf("vec%0d", k), exp_q.pop_front());
      @(negedge clk);
    end

    // Asynchronous reset between edges while in MEM_WAIT.
    drive(5'b00001);
    @(negedge clk);
    #2;
    check("pre_reset_mem_wait", {5'b01111, 5'b10000, 1'b0, 2'd1});
    reset = 1'b1;
    #1;
    check("async_reset", {5'b00000, 5'b11111, 1'b0, 2'd0});
    reset = 1'b0;
    drive(5'b00000);
    @(negedge clk);
    #2;
    check("after_reset_idle", {5'b00000, 5'b00000, 1'b0, 2'd0});
    @(negedge clk);

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(5'b00010);
    repeat (20) @(negedge clk);
    drive(5'b10000);
    repeat (3) @(negedge clk);
    drive(5'b00000);
    @(negedge clk);
    #2;
    check_val("stall_cycles_sat", 32'(stall_cycles), 32'd15);
    check_val("flush_events", 32'(flush_events), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
